rv_data_bus_arbiter: RTL and testbench

- Shares one peripheral data-memory slave port (key device, LED and similar single-port devices on the req/we/be/addr/wdata + rvalid/rdata bus) between two requesters: m0 = core LSU, m1 = debug/DMA master.
- Round-robin arbitration with one transaction outstanding at a time.
- Timeout watchdog: a slave that never answers cannot hang a master.
- Sits between the masters and the peripheral address decoder.

---
 rtl/rv_data_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_rv_data_bus_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rv_data_bus_arbiter.sv
// rv_data_bus_arbiter: shares one req/we/be/addr/wdata + rvalid/rdata slave
// port between the core LSU (m0) and a debug/DMA master (m1). Round-robin
// arbitration, one transaction outstanding, with a timeout watchdog that
// answers the owner with an error if the slave never responds.
module rv_data_bus_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk_i,
    input  logic              arst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [XLEN/8-1:0] m0_be_i,
    input  logic [XLEN-1:0]   m0_addr_i,
    input  logic [XLEN-1:0]   m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [XLEN-1:0]   m0_rdata_o,
    output logic              m0_err_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [XLEN/8-1:0] m1_be_i,
    input  logic [XLEN-1:0]   m1_addr_i,
    input  logic [XLEN-1:0]   m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [XLEN-1:0]   m1_rdata_o,
    output logic              m1_err_o,

    output logic              s_req_o,
    output logic              s_we_o,
    output logic [XLEN/8-1:0] s_be_o,
    output logic [XLEN-1:0]   s_addr_o,
    output logic [XLEN-1:0]   s_wdata_o,
    input  logic              s_rvalid_i,
    input  logic [XLEN-1:0]   s_rdata_i
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;   // 0 = m0, 1 = m1
    logic            prio_q,  prio_d;    // master that wins a tie
    logic [TO_W-1:0] count_q, count_d;

    // Master request fields gathered into arrays so arbitration indexes them.
    logic [1:0]        m_req;
    logic [1:0]        m_we;
    logic [XLEN/8-1:0] m_be    [2];
    logic [XLEN-1:0]   m_addr  [2];
    logic [XLEN-1:0]   m_wdata [2];

    assign m_req      = {m1_req_i, m0_req_i};
    assign m_we       = {m1_we_i,  m0_we_i};
    assign m_be[0]    = m0_be_i;
    assign m_be[1]    = m1_be_i;
    assign m_addr[0]  = m0_addr_i;
    assign m_addr[1]  = m1_addr_i;
    assign m_wdata[0] = m0_wdata_i;
    assign m_wdata[1] = m1_wdata_i;

    // Per-master response signals, fanned out to the ports below.
    logic [1:0]      gnt;
    logic [1:0]      rvalid;
    logic [1:0]      err;
    logic [XLEN-1:0] rdata [2];

    logic winner;
    logic timeout_hit;

    // Winner is prio on a tie, otherwise whichever master is requesting.
    assign winner      = (&m_req) ? prio_q : m_req[1];
    // Depends only on the counter, so s_rvalid_i never reaches gnt or s_req.
    assign timeout_hit = (count_q == TO_W'(TIMEOUT - 1));

    // State, owner, priority and watchdog counter registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            count_q <= count_d;
        end
    end

    // Next-state logic plus the combinational grant, forward and response paths.
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        count_d   = count_q;
        gnt       = '0;
        rvalid    = '0;
        err       = '0;
        rdata[0]  = '0;
        rdata[1]  = '0;
        s_req_o   = 1'b0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;

        unique case (state_q)
            IDLE: begin
                // A stray s_rvalid_i here (late or post-reset) is ignored.
                if (|m_req) begin
                    gnt[winner] = 1'b1;
                    s_req_o     = 1'b1;
                    s_we_o      = m_we[winner];
                    s_be_o      = m_be[winner];
                    s_addr_o    = m_addr[winner];
                    s_wdata_o   = m_wdata[winner];
                    owner_d     = winner;
                    count_d     = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                count_d = count_q + 1'b1;
                if (s_rvalid_i) begin
                    // A real response beats a timeout in the same cycle.
                    rvalid[owner_q] = 1'b1;
                    rdata[owner_q]  = s_rdata_i;
                    prio_d          = ~owner_q;
                    state_d         = IDLE;
                end else if (timeout_hit) begin
                    rvalid[owner_q] = 1'b1;
                    err[owner_q]    = 1'b1;
                    prio_d          = ~owner_q;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset must silence outputs even while a master keeps requesting.
        if (arst_i) begin
            gnt       = '0;
            rvalid    = '0;
            err       = '0;
            rdata[0]  = '0;
            rdata[1]  = '0;
            s_req_o   = 1'b0;
            s_we_o    = 1'b0;
            s_be_o    = '0;
            s_addr_o  = '0;
            s_wdata_o = '0;
        end
    end

    assign m0_gnt_o    = gnt[0];
    assign m0_rvalid_o = rvalid[0];
    assign m0_rdata_o  = rdata[0];
    assign m0_err_o    = err[0];
    assign m1_gnt_o    = gnt[1];
    assign m1_rvalid_o = rvalid[1];
    assign m1_rdata_o  = rdata[1];
    assign m1_err_o    = err[1];

endmodule

// File: tb/tb_rv_data_bus_arbiter.sv
// Directed bench for rv_data_bus_arbiter with TIMEOUT = 4: single read,
// contention and round-robin, write forwarding, timeout with a late response,
// response/timeout collision, and reset while a transaction is outstanding.
module tb_rv_data_bus_arbiter;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              arst;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [XLEN/8-1:0] m0_be, m1_be;
    logic [XLEN-1:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic              m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [XLEN-1:0]   m0_rdata, m1_rdata;
    logic              s_req, s_we, s_rvalid;
    logic [XLEN/8-1:0] s_be;
    logic [XLEN-1:0]   s_addr, s_wdata, s_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    rv_data_bus_arbiter #(.XLEN(XLEN), .TIMEOUT(4), .TO_W(8)) dut (
        .clk_i(clk), .arst_i(arst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
        .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
        .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr),
        .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs mid-cycle.
    task automatic settle();
        #1;
    endtask

    function automatic logic [7:0] flags();
        return {m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, s_req, s_we};
    endfunction

    initial begin
        arst = 1'b1;
        m0_req = 0; m0_we = 0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
        s_rvalid = 0; s_rdata = '0;
        tick(); tick();
        check("reset_flags", flags(), 8'h00);
        check("reset_data", {m0_rdata, m1_rdata}, 64'h0);
        arst = 1'b0;
        tick();

        // ---- Single read by m0, slave answers 3 cycles after s_req ----
        m0_req = 1; m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000;
        settle();
        check("rd_gnt", {m0_gnt, m1_gnt, s_req, s_we}, 4'b1010);
        check("rd_addr", s_addr, 64'h1000);
        tick(); m0_req = 0;                               // cycle 1
        settle();
        check("rd_c1", flags(), 8'h00);
        tick();                                           // cycle 2
        check("rd_c2", flags(), 8'h00);
        tick(); s_rvalid = 1; s_rdata = 32'h1;            // cycle 3
        settle();
        check("rd_rvalid", {m0_rvalid, m0_err, m1_rvalid, m1_err}, 4'b1000);
        check("rd_rdata", m0_rdata, 64'h1);
        check("rd_m1_rdata", m1_rdata, 64'h0);
        tick(); s_rvalid = 0;

        // ---- Contention after reset: m0 first, then m1, then m0 ----
        arst = 1; tick(); arst = 0; tick();
        m0_req = 1; m1_req = 1; m0_addr = 32'hA0; m1_addr = 32'hB0;
        settle();
        check("ct_gnt0", {m0_gnt, m1_gnt}, 2'b10);
        check("ct_addr0", s_addr, 64'hA0);
        tick(); m0_req = 0;
        settle();
        check("ct_wait_nognt", {m0_gnt, m1_gnt, s_req}, 3'b000);
        s_rvalid = 1; s_rdata = 32'hAA;
        settle();
        check("ct_rsp0", {m0_rvalid, m1_rvalid, m0_rdata}, {2'b10, 32'hAA});
        check("ct_rsp0_nognt", m1_gnt, 1'b0);
        tick(); s_rvalid = 0; m0_req = 1;                 // m0 re-requests at once
        settle();
        check("ct_gnt1", {m0_gnt, m1_gnt}, 2'b01);
        check("ct_addr1", s_addr, 64'hB0);
        tick(); m1_req = 0; s_rvalid = 1; s_rdata = 32'h55;
        settle();
        check("ct_rsp1", {m0_rvalid, m1_rvalid, m1_rdata, m0_rdata},
              {2'b01, 32'h55, 32'h0});
        tick(); s_rvalid = 0;
        settle();
        check("ct_gnt0_again", {m0_gnt, m1_gnt}, 2'b10);
        tick(); m0_req = 0; s_rvalid = 1; s_rdata = 32'h0;
        tick(); s_rvalid = 0;                             // prio now m1

        // ---- Write by m1, slave answers 1 cycle later ----
        m1_req = 1; m1_we = 1; m1_be = 4'b0011; m1_wdata = 32'hDEAD_BEEF;
        m1_addr = 32'h0000_0040;
        settle();
        check("wr_fwd", {m1_gnt, s_req, s_we, s_be}, {3'b111, 4'b0011});
        check("wr_wdata", {s_wdata, s_addr}, {32'hDEAD_BEEF, 32'h40});
        tick(); m1_req = 0; m1_we = 0;
        settle();
        check("wr_wait", {s_req, m1_rvalid}, 2'b00);
        s_rvalid = 1; s_rdata = 32'h0;
        settle();
        check("wr_rsp", {m1_rvalid, m1_err, m0_rvalid}, 3'b100);
        tick(); s_rvalid = 0;                             // prio now m0

        // ---- Timeout: slave silent, error on the 4th WAIT cycle ----
        s_rdata = 32'h1234_5678;
        m0_req = 1;
        settle();
        check("to_gnt", m0_gnt, 1'b1);
        tick(); m0_req = 0;                               // WAIT 1
        settle();
        check("to_w1", {m0_rvalid, m0_err}, 2'b00);
        tick();                                           // WAIT 2
        check("to_w2", {m0_rvalid, m0_err}, 2'b00);
        tick();                                           // WAIT 3
        check("to_w3", {m0_rvalid, m0_err}, 2'b00);
        tick();                                           // WAIT 4
        check("to_err", {m0_rvalid, m0_err, m1_rvalid}, 3'b110);
        check("to_rdata", m0_rdata, 64'h0);
        tick();                                           // IDLE
        check("to_idle", flags(), 8'h00);
        tick(); s_rvalid = 1;                             // late pulse
        settle();
        check("to_late", {m0_rvalid, m0_err, m1_rvalid, m1_err}, 4'b0000);
        check("to_late_data", {m0_rdata, m1_rdata}, 64'h0);
        tick(); s_rvalid = 0;

        // ---- Other master granted; response collides with timeout ----
        m1_req = 1; m1_addr = 32'h300;
        settle();
        check("col_gnt", {m0_gnt, m1_gnt}, 2'b01);
        tick(); m1_req = 0;                               // WAIT 1
        tick();                                           // WAIT 2
        tick();                                           // WAIT 3
        check("col_w3", m1_rvalid, 1'b0);
        tick(); s_rvalid = 1; s_rdata = 32'hCAFE_F00D;    // WAIT 4
        settle();
        check("col_rsp", {m1_rvalid, m1_err}, 2'b10);
        check("col_rdata", m1_rdata, 64'hCAFE_F00D);
        tick(); s_rvalid = 0;                             // prio now m0

        // ---- m0 completes (prio -> m1), m1 granted, reset mid-WAIT ----
        m0_req = 1;
        settle();
        check("rs_pre_gnt", m0_gnt, 1'b1);
        tick(); m0_req = 0; s_rvalid = 1; s_rdata = 32'h0;
        tick(); s_rvalid = 0; m1_req = 1;
        settle();
        check("rs_gnt", m1_gnt, 1'b1);
        tick(); m1_req = 0;                               // WAIT 1
        #2; arst = 1;
        settle();
        check("rs_async", flags(), 8'h00);
        check("rs_async_data", {m0_rdata, m1_rdata, s_addr}, 96'h0);
        tick(); arst = 0;
        tick(); s_rvalid = 1; s_rdata = 32'h77;           // stray response
        settle();
        check("rs_stray", {m0_rvalid, m1_rvalid, m0_err, m1_err}, 4'b0000);
        tick(); s_rvalid = 0;
        m0_req = 1; m1_req = 1;
        settle();
        check("rs_prio_m0", {m0_gnt, m1_gnt}, 2'b10);
        tick(); m0_req = 0; m1_req = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
